// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and data access; data goes first.
// Optional one-entry fetch buffer is built when MEM_ARB_IBUF_EN is defined.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_data,
  output logic          if_valid,
  input  logic [1:0]    dm_read,
  input  logic [1:0]    dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);
  localparam int CW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CW:0]   wait_cnt_inc;
  logic [DW-1:0] if_data_reg, if_data_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;
  logic          if_served_reg, if_served_next;
  logic          dm_served_reg, dm_served_next;
  logic          bus_err_reg, bus_err_next;
  logic          dm_pending, dm_is_store, wait_expired;
  logic          ibuf_hit;
  logic [DW-1:0] ibuf_rdata;

  assign dm_pending   = (dm_read != 2'b00) || (dm_write != 2'b00);
  assign dm_is_store  = (dm_write != 2'b00);
  assign wait_cnt_inc = {1'b0, wait_cnt_reg} + CW1'(1);
  // Expires on the cycle whose missing ack would make the wait count reach TIMEOUT.
  assign wait_expired = (wait_cnt_inc == CW1'(TIMEOUT));

  assign if_data  = if_data_reg;
  assign dm_rdata = dm_rdata_reg;
  assign bus_err  = bus_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      if_data_reg   <= '0;
      dm_rdata_reg  <= '0;
      if_served_reg <= 1'b0;
      dm_served_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      if_data_reg   <= if_data_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_served_reg <= if_served_next;
      dm_served_reg <= dm_served_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = '0;
    if_data_next   = if_data_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_served_next = if_served_reg;
    dm_served_next = dm_served_reg;
    bus_err_next   = bus_err_reg;
    bus_req        = 1'b0;
    bus_we         = 1'b0;
    bus_size       = 2'b00;
    bus_addr       = '0;
    bus_wdata      = '0;
    if_valid       = 1'b0;
    dm_valid       = 1'b0;
    // Reset is folded in so the pipeline is released the instant reset asserts.
    stall          = !rst && (state_reg != DONE) && (if_req || dm_pending);

    case (state_reg)
      IDLE: begin
        if_served_next = 1'b0;
        dm_served_next = 1'b0;
        if (dm_pending) begin
          state_next = DATA;
        end else if (if_req && ibuf_hit) begin
          state_next     = DONE;
          if_served_next = 1'b1;
          if_data_next   = ibuf_rdata;
        end else if (if_req) begin
          state_next = INST;
        end
      end

      DATA: begin
        bus_req   = 1'b1;
        bus_we    = dm_is_store;
        bus_size  = dm_is_store ? dm_write : dm_read;
        bus_addr  = dm_addr;
        bus_wdata = dm_wdata;
        if (bus_ack) begin
          dm_served_next = 1'b1;
          if (!dm_is_store) dm_rdata_next = bus_rdata;
          state_next = if_req ? INST : DONE;
        end else if (wait_expired) begin
          dm_served_next = 1'b1;
          dm_rdata_next  = '0;
          bus_err_next   = 1'b1;
          state_next     = DONE;
        end else begin
          wait_cnt_next = wait_cnt_inc[CW-1:0];
        end
      end

      INST: begin
        bus_req  = 1'b1;
        bus_size = 2'b11;
        bus_addr = if_addr;
        if (bus_ack) begin
          if_served_next = 1'b1;
          if_data_next   = bus_rdata;
          state_next     = DONE;
        end else if (wait_expired) begin
          if_served_next = 1'b1;
          if_data_next   = '0;
          bus_err_next   = 1'b1;
          state_next     = DONE;
        end else begin
          wait_cnt_next = wait_cnt_inc[CW-1:0];
        end
      end

      DONE: begin
        if_valid   = if_served_reg;
        dm_valid   = dm_served_reg;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef MEM_ARB_IBUF_EN
  logic [AW-1:0] ibuf_addr_reg, ibuf_addr_next;
  logic [DW-1:0] ibuf_data_reg, ibuf_data_next;
  logic          ibuf_valid_reg, ibuf_valid_next;

  assign ibuf_hit   = ibuf_valid_reg && (ibuf_addr_reg == if_addr);
  assign ibuf_rdata = ibuf_data_reg;

  always_comb begin
    ibuf_addr_next  = ibuf_addr_reg;
    ibuf_data_next  = ibuf_data_reg;
    ibuf_valid_next = ibuf_valid_reg;
    if (state_reg == INST) begin
      if (bus_ack) begin
        ibuf_addr_next  = if_addr;
        ibuf_data_next  = bus_rdata;
        ibuf_valid_next = 1'b1;
      end else if (wait_expired) begin
        ibuf_valid_next = 1'b0;
      end
    end else if (state_reg == DATA) begin
      // Any store touching the buffered word makes the cached instruction stale.
      if (bus_ack && dm_is_store && (dm_addr[AW-1:2] == ibuf_addr_reg[AW-1:2]))
        ibuf_valid_next = 1'b0;
      else if (!bus_ack && wait_expired)
        ibuf_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibuf_addr_reg  <= '0;
      ibuf_data_reg  <= '0;
      ibuf_valid_reg <= 1'b0;
    end else begin
      ibuf_addr_reg  <= ibuf_addr_next;
      ibuf_data_reg  <= ibuf_data_next;
      ibuf_valid_reg <= ibuf_valid_next;
    end
  end
`else
  assign ibuf_hit   = 1'b0;
  assign ibuf_rdata = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a bus responder model and a completion monitor pop expectation queues.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_data;
  logic          if_valid;
  logic [1:0]    dm_read = 2'b00;
  logic [1:0]    dm_write = 2'b00;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          stall;
  logic          bus_req;
  logic          bus_we;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          bus_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          ifv;
    bit          dmv;
    logic [31:0] ifd;
    logic [31:0] dmd;
    int          lat;
    int          t0;
  } vexp_t;
  typedef struct {
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bexp_t;
  typedef struct {
    int          lat;
    logic [31:0] rdata;
  } resp_t;

  vexp_t vq[$];
  bexp_t bq[$];
  resp_t rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_v(input bit ifv, input bit dmv, input logic [31:0] ifd,
                        input logic [31:0] dmd, input int lat);
    vexp_t e;
    e.ifv = ifv; e.dmv = dmv; e.ifd = ifd; e.dmd = dmd; e.lat = lat; e.t0 = cyc;
    vq.push_back(e);
  endtask

  task automatic push_bus(input bit we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
    bexp_t b;
    resp_t r;
    b.we = we; b.size = size; b.addr = addr; b.wdata = wdata;
    r.lat = lat; r.rdata = rdata;
    bq.push_back(b);
    rq.push_back(r);
  endtask

  task automatic issue(input bit ifr, input logic [31:0] ia, input logic [1:0] rd,
                       input logic [1:0] wr, input logic [31:0] da, input logic [31:0] wd);
    @(posedge clk);
    #1;
    if_req = ifr; if_addr = ia; dm_read = rd; dm_write = wr; dm_addr = da; dm_wdata = wd;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0; dm_read = 2'b00; dm_write = 2'b00; dm_addr = '0; dm_wdata = '0;
  endtask

  // Holds the request until a completion pulse, counting any cycle where the pipeline was released early.
  task automatic wait_done(input string name);
    int  stall_low = 0;
    bit  got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_valid || dm_valid) got = 1'b1;
      else if (!stall) stall_low++;
    end
    check({name, "_completed"}, 32'(got), 32'd1);
    check({name, "_stall_held"}, 32'(stall_low), 32'd0);
    clear_inputs();
  endtask

  // Bus responder: pops a response/expectation on each new request, acks after the programmed latency.
  bit    req_seen = 1'b0;
  int    age = 0;
  resp_t cur;
  always @(posedge clk) begin
    #1;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    if (bus_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        age = 0;
        if (rq.size() > 0) cur = rq.pop_front();
        else begin
          cur.lat = -1;
          cur.rdata = '0;
        end
        $display("bus  cyc=%0d we=%0b size=%0b addr=0x%08h wdata=0x%08h", cyc, bus_we, bus_size,
                 bus_addr, bus_wdata);
        if (bq.size() == 0) begin
          n_checks++;
          $display("FAIL bus_unexpected: got request addr 0x%08h required none", bus_addr);
        end else begin
          bexp_t b;
          b = bq.pop_front();
          check("bus_we", 32'(bus_we), 32'(b.we));
          check("bus_size", 32'(bus_size), 32'(b.size));
          check("bus_addr", bus_addr, b.addr);
          check("bus_wdata", bus_wdata, b.wdata);
        end
      end else begin
        age++;
      end
      if (age == cur.lat) begin
        bus_ack   = 1'b1;
        bus_rdata = cur.rdata;
        req_seen  = 1'b0;
      end
    end else begin
      req_seen = 1'b0;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (if_valid || dm_valid) begin
      $display("done cyc=%0d if_valid=%0b if_data=0x%08h dm_valid=%0b dm_rdata=0x%08h", cyc,
               if_valid, if_data, dm_valid, dm_rdata);
      if (vq.size() == 0) begin
        n_checks++;
        $display("FAIL valid_unexpected: got a completion pulse required none");
      end else begin
        vexp_t e;
        e = vq.pop_front();
        check("if_valid", 32'(if_valid), 32'(e.ifv));
        check("dm_valid", 32'(dm_valid), 32'(e.dmv));
        if (e.ifv) check("if_data", if_data, e.ifd);
        if (e.dmv) check("dm_rdata", dm_rdata, e.dmd);
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
        check("stall_in_done", 32'(stall), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state, with a request present to prove reset masks stall.
    if_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_dm_valid", 32'(dm_valid), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single fetch, ack 3 cycles after request rises.
    push_bus(1'b0, 2'b11, 32'h100, 32'h0, 3, 32'h8C220004);
    issue(1'b1, 32'h100, 2'b00, 2'b00, 32'h0, 32'h0);
    push_v(1'b1, 1'b0, 32'h8C220004, 32'h0, 5);
    #1;
    check("fetch_stall_on_request", 32'(stall), 32'd1);
    wait_done("fetch");

    // Load and fetch together: data first, then instruction.
    push_bus(1'b0, 2'b11, 32'h40, 32'h0, 1, 32'h11223344);
    push_bus(1'b0, 2'b11, 32'h104, 32'h0, 1, 32'h55667788);
    issue(1'b1, 32'h104, 2'b11, 2'b00, 32'h40, 32'h0);
    push_v(1'b1, 1'b1, 32'h55667788, 32'h11223344, 5);
    wait_done("load_fetch");

    // Byte store: load data must not change.
    push_bus(1'b1, 2'b01, 32'h43, 32'hAB, 2, 32'hDEADBEEF);
    issue(1'b0, 32'h0, 2'b00, 2'b01, 32'h43, 32'hAB);
    push_v(1'b0, 1'b1, 32'h0, 32'h11223344, 4);
    wait_done("store_byte");

    // Read and write together: write wins; ack in the same cycle the request rises.
    push_bus(1'b1, 2'b10, 32'h80, 32'h1234, 0, 32'hCAFEF00D);
    issue(1'b0, 32'h0, 2'b11, 2'b10, 32'h80, 32'h1234);
    push_v(1'b0, 1'b1, 32'h0, 32'h11223344, 2);
    wait_done("rw_conflict");

    // Fetch that is never acknowledged.
    push_bus(1'b0, 2'b11, 32'h300, 32'h0, -1, 32'h0);
    issue(1'b1, 32'h300, 2'b00, 2'b00, 32'h0, 32'h0);
    push_v(1'b1, 1'b0, 32'h0, 32'h0, TO + 1);
    #1;
    check("timeout_err_before", 32'(bus_err), 32'd0);
    wait_done("timeout");
    check("timeout_bus_err", 32'(bus_err), 32'd1);

    // Byte load after the timeout; the error flag must persist.
    push_bus(1'b0, 2'b01, 32'h41, 32'h0, 0, 32'h000000FF);
    issue(1'b0, 32'h0, 2'b01, 2'b00, 32'h41, 32'h0);
    push_v(1'b0, 1'b1, 32'h0, 32'h000000FF, 2);
    wait_done("load_byte");
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset in the middle of a data access.
    push_bus(1'b0, 2'b11, 32'h50, 32'h0, -1, 32'h0);
    issue(1'b0, 32'h0, 2'b11, 2'b00, 32'h50, 32'h0);
    repeat (2) @(negedge clk);
    check("mid_bus_req_before", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_valid", 32'(if_valid | dm_valid), 32'd0);
    check("mid_rst_bus_err", 32'(bus_err), 32'd0);
    check("mid_rst_dm_rdata", dm_rdata, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    // Normal fetch after reset recovery, ack 1 cycle after request.
    push_bus(1'b0, 2'b11, 32'h104, 32'h0, 1, 32'h0BADF00D);
    issue(1'b1, 32'h104, 2'b00, 2'b00, 32'h0, 32'h0);
    push_v(1'b1, 1'b0, 32'h0BADF00D, 32'h0, 3);
    wait_done("post_reset_fetch");

    // Repeated fetch of 0x200, then a store to it, then a fetch again.
    push_bus(1'b0, 2'b11, 32'h200, 32'h0, 1, 32'hA0A0A0A0);
    issue(1'b1, 32'h200, 2'b00, 2'b00, 32'h0, 32'h0);
    push_v(1'b1, 1'b0, 32'hA0A0A0A0, 32'h0, 3);
    wait_done("fetch_200_first");

`ifdef MEM_ARB_IBUF_EN
    issue(1'b1, 32'h200, 2'b00, 2'b00, 32'h0, 32'h0);
    push_v(1'b1, 1'b0, 32'hA0A0A0A0, 32'h0, 1);
    wait_done("fetch_200_hit");
`else
    push_bus(1'b0, 2'b11, 32'h200, 32'h0, 1, 32'hA0A0A0A0);
    issue(1'b1, 32'h200, 2'b00, 2'b00, 32'h0, 32'h0);
    push_v(1'b1, 1'b0, 32'hA0A0A0A0, 32'h0, 3);
    wait_done("fetch_200_again");
`endif

    push_bus(1'b1, 2'b11, 32'h200, 32'h5, 0, 32'h0);
    issue(1'b0, 32'h0, 2'b00, 2'b11, 32'h200, 32'h5);
    push_v(1'b0, 1'b1, 32'h0, 32'h0, 2);
    wait_done("store_200");

    push_bus(1'b0, 2'b11, 32'h200, 32'h0, 1, 32'hB0B0B0B0);
    issue(1'b1, 32'h200, 2'b00, 2'b00, 32'h0, 32'h0);
    push_v(1'b1, 1'b0, 32'hB0B0B0B0, 32'h0, 3);
    wait_done("fetch_200_after_store");

    repeat (3) @(negedge clk);
    check("completions_left", 32'(vq.size()), 32'd0);
    check("bus_requests_left", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
